// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// state | meaning
// IDLE  | waiting for start_i; early-exit cases resolve here straight to DONE
// CALC  | one multiply/divide bit per cycle, count 0..W-1
// SIGN  | sign fix-up and result select, result registered
// DONE  | done_o pulse for one cycle
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] srcA_i,
    input  logic [DATA_WIDTH-1:0] srcB_i,
    input  logic                  kill_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [W-1:0]     mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     result_q, result_d;

    logic             sign_a_in, sign_b_in, b_zero, div_ovf;
    logic [W:0]       rem_shift, rem_diff;
    logic [2*W-1:0]   addend, prod_fix;
    logic [W-1:0]     quo_fix, rem_fix, res_sel;

    assign sign_a_in = srcA_i[W-1] & ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                                      (op_i == OP_DIV)  || (op_i == OP_REM));
    assign sign_b_in = srcB_i[W-1] & ((op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM));
    assign b_zero    = (srcB_i == '0);
    assign div_ovf   = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                       (srcA_i == {1'b1, {(W-1){1'b0}}}) && (srcB_i == '1);

    // For divide, acc holds {remainder, quotient}; mag_a shifts left to feed dividend bits MSB first.
    assign rem_shift = {acc_q[2*W-1:W], mag_a_q[W-1]};
    assign rem_diff  = rem_shift - {1'b0, mag_b_q};
    assign addend    = {{W{1'b0}}, mag_a_q} << count_q;

    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_fix  = ((op_q == OP_DIV) && (sign_a_q ^ sign_b_q)) ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix  = ((op_q == OP_REM) && sign_a_q) ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        res_sel = '0;
        case (op_q)
            OP_MUL:                       res_sel = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_sel = prod_fix[2*W-1:W];
            3'b100, 3'b101:               res_sel = quo_fix;
            default:                      res_sel = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d     = op_i;
                    sign_a_d = sign_a_in;
                    sign_b_d = sign_b_in;
                    mag_a_d  = sign_a_in ? -srcA_i : srcA_i;
                    mag_b_d  = sign_b_in ? -srcB_i : srcB_i;
                    acc_d    = '0;
                    count_d  = '0;
                    if (op_i[2] && b_zero) begin
                        result_d = op_i[1] ? srcA_i : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = op_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    mag_a_d = mag_a_q << 1;
                    if (!rem_diff[W]) begin
                        acc_d = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
                    end
                end else if (mag_b_q[count_q]) begin
                    acc_d = acc_q + addend;
                end
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(W-1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                result_d = res_sel;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // A flush drops the operation without touching the visible result.
        if (kill_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == S_CALC) || (state_q == S_SIGN);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, early exits, kill and reset.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
    logic [2:0]   op_i = 3'b000;
    logic [W-1:0] srcA_i = '0;
    logic [W-1:0] srcB_i = '0;
    logic         kill_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .srcA_i(srcA_i), .srcB_i(srcB_i), .kill_i(kill_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    // Starts an op at a negedge (cycle 0) and watches up to 40 cycles for done_o.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int dcyc, output logic [31:0] res, output int bcnt,
                          output logic idle_ok);
        @(negedge clk);
        idle_ok = (busy_o === 1'b0) && (done_o === 1'b0);
        start_i = 1'b1; op_i = op; srcA_i = a; srcB_i = b;
        dcyc = -1; res = 'x; bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start_i = 1'b0; srcA_i = $urandom; srcB_i = $urandom; op_i = 3'($urandom);
            end
            if (busy_o === 1'b1) bcnt++;
            if (done_o === 1'b1) begin
                dcyc = k; res = result_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", result_o); end
    endtask

    task automatic test_mul();
        int d, bc; logic [31:0] r; logic ok;
        run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, d, r, bc, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mul_idle: busy/done high in cycle 0"); end
        checks++; if (d != 34) begin failures++; $display("FAIL mul_latency: got %0d expected 34", d); end
        checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result: got %h expected ffffffeb", r); end
        checks++; if (bc != 33) begin failures++; $display("FAIL mul_busy_cycles: got %0d expected 33", bc); end
    endtask

    task automatic test_mulh();
        logic [2:0]  ops[3] = '{3'b001, 3'b010, 3'b011};
        logic [31:0] exp[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        int d, bc; logic [31:0] r; logic ok;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, r, bc, ok);
            checks++; if (r !== exp[i] || d != 34) begin failures++;
                $display("FAIL mulh_op%0d: got %h at cycle %0d expected %h at cycle 34", ops[i], r, d, exp[i]); end
        end
    endtask

    task automatic test_early_exit();
        logic [2:0]  ops[4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int d, bc; logic [31:0] r; logic ok;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], d, r, bc, ok);
            checks++; if (r !== exp[i]) begin failures++; $display("FAIL early%0d_result: got %h expected %h", i, r, exp[i]); end
            checks++; if (d != 1 || bc != 0 || ok !== 1'b1) begin failures++;
                $display("FAIL early%0d_timing: done cycle %0d busy cycles %0d expected 1 and 0", i, d, bc); end
        end
    endtask

    // Ops issued back to back: each start lands the cycle after the previous done_o.
    task automatic test_back_to_back();
        logic [2:0]  ops[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int d, bc; logic [31:0] r; logic ok;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], d, r, bc, ok);
            checks++; if (r !== exp[i]) begin failures++; $display("FAIL div%0d_result: got %h expected %h", i, r, exp[i]); end
            checks++; if (d != 34 || bc != 33 || ok !== 1'b1) begin failures++;
                $display("FAIL div%0d_timing: done cycle %0d busy cycles %0d expected 34 and 33", i, d, bc); end
        end
    endtask

    task automatic test_kill(input logic [31:0] prior);
        int d, bc, seen; logic [31:0] r; logic ok;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b101; srcA_i = 32'd100; srcB_i = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
        end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL kill_busy_before: got %b expected 1", busy_o); end
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++;
            $display("FAIL kill_idle: busy %b done %b expected 0 0", busy_o, done_o); end
        checks++; if (result_o !== prior) begin failures++; $display("FAIL kill_result: got %h expected %h", result_o, prior); end
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL kill_quiet: got %0d active cycles expected 0", seen); end
        run_op(3'b000, 32'd3, 32'd4, d, r, bc, ok);
        checks++; if (r !== 32'd12 || d != 34) begin failures++;
            $display("FAIL kill_then_mul: got %h at cycle %0d expected 0000000c at cycle 34", r, d); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b000; srcA_i = 32'd5; srcB_i = 32'd6;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
        end
        rst = 1'b0; start_i = 1'b1; op_i = 3'b100; srcA_i = 32'd9; srcB_i = 32'd0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++;
            $display("FAIL rst_mid_ctrl: busy %b done %b expected 0 0", busy_o, done_o); end
        checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL rst_mid_result: got %h expected 00000000", result_o); end
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) seen++;
        end
        checks++; if (seen != 0 || result_o !== 32'h0) begin failures++;
            $display("FAIL rst_start_ignored: %0d active cycles result %h expected 0 and 00000000", seen, result_o); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_mul();
        test_mulh();
        test_early_exit();
        test_back_to_back();
        test_kill(32'd2);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that sits beside the execute stage and feeds its result to the memory stage through the execute output path. It accepts one operation at a time from execute, asserts `busy_o` so the hazard logic stalls fetch/decode/execute, and pulses `done_o` with a registered result. Multiply uses shift-add and divide uses restoring division, one bit per cycle. Divide-by-zero and signed overflow complete early with RISC-V defined results.

## Interface
- `DATA_WIDTH`, 32, operand/result width; the iteration count equals `DATA_WIDTH`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-low; takes effect on a rising edge while low.
- `start_i`  in  1  request an operation; sampled only in IDLE.
- `op_i`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `srcA_i`  in  DATA_WIDTH  rs1 value (multiplicand / dividend).
- `srcB_i`  in  DATA_WIDTH  rs2 value (multiplier / divisor).
- `kill_i`  in  1  flush; abort any operation in flight.
- `busy_o`  out  1  high in CALC and SIGN; the stall request.
- `done_o`  out  1  one-cycle pulse; `result_o` is valid in that cycle.
- `result_o`  out  DATA_WIDTH  registered result; holds until the next `done_o`.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE with `start_i`=1 and `kill_i`=0:
  - Latch `op_i` and the operands.
  - Compute operand signs: A is signed for MULH, MULHSU, DIV and REM; B is signed for MULH, DIV and REM; MUL and all unsigned ops treat both operands as unsigned.
  - Store operand magnitudes.
  - Clear the 2W-bit accumulator and the counter.
  - Go to CALC.
- Early exit from IDLE (go directly to DONE with the result registered; CALC is skipped):
  - DIV/DIVU with B=0: quotient = all ones.
  - REM/REMU with B=0: remainder = A.
  - DIV with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000.
  - REM with the same operands: remainder = 0.
- CALC, multiply: each cycle, if multiplier bit[count] is 1, add multiplicand<<count into the 2W-bit product.
- CALC, divide: restoring division, MSB first. Shift the remainder left and bring in the next dividend bit. If remainder ≥ divisor, subtract and set the quotient bit.
- Counter runs 0..W-1. On the edge where count=W-1 completes, go to SIGN.
- SIGN:
  - Negate the product when sign_a XOR sign_b (signed mul variants only).
  - Negate the quotient when signs differ (DIV only).
  - Negate the remainder when the dividend is negative (REM only).
  - Select the result: MUL = low W bits, MULH* = high W bits, DIV* = quotient, REM* = remainder.
  - Register the result into `result_o` and go to DONE.
- DONE: `done_o`=1 for one cycle, then unconditionally to IDLE. `start_i` is ignored in DONE.
- `kill_i`=1 in any state: next state IDLE, no `done_o`, `result_o` unchanged. `kill_i` beats `start_i` in IDLE.
- `start_i` is ignored in CALC, SIGN and DONE. Operand inputs are don't-care after acceptance.
- All arithmetic is unsigned on magnitudes; W+1-bit subtractor for divide; 2W-bit adder for multiply. Negation is two's complement, wrapping at width.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, counter 0, `result_o`=0, `done_o`=0, `busy_o`=0. Reset overrides `kill_i` and `start_i`, and aborts an operation in progress.
- Normal latency: `start_i` in cycle 0 → CALC in cycles 1..W → SIGN in cycle W+1 → `done_o` in cycle W+2 (cycle 34 for W=32).
- Early-exit latency: `done_o` in cycle 1. `busy_o` stays low throughout.
- `busy_o`: low in cycle 0, high in cycles 1..W+1, low in the `done_o` cycle.
- Earliest back-to-back `start_i` is the cycle after `done_o` (cycle W+3).
- `done_o` never asserts two cycles in a row.

## Test plan
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD) → `result_o`=0xFFFFFFEB with `done_o` in cycle 34; `busy_o` high in cycles 1..33.
- MULH/MULHSU/MULHU with A=0xFFFFFFFF, B=0xFFFFFFFF → 0x00000000, 0xFFFFFFFF and 0xFFFFFFFE respectively.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; REM 0x80000000/-1 → 0. Each completes with `done_o` in cycle 1 and `busy_o` never high.
- Start DIVU 100/7, assert `kill_i` in cycle 10 → IDLE next cycle, no `done_o`, `result_o` keeps its prior value; a new MUL 3×4 started immediately after → 12.
- Drive `rst`=0 in cycle 15 of a multiply → next cycle `busy_o`=0, `done_o`=0, `result_o`=0; `start_i` held during reset is not accepted.
